// File: rtl/bus_arbiter_if.sv
// Signal bundle between the IF/MEM pipeline stages, the bus arbiter and the external memory bus.
// The arbiter uses the slave modport; the pipeline/bus environment uses the master modport.
interface bus_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        stallreq_if;
  logic        stallreq_mem;

  modport slave (
    input  if_req, if_addr, if_flush, mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
           bus_rdata, bus_ack,
    output if_rdata, if_ready, mem_rdata, mem_ready, bus_err,
           bus_req, bus_we, bus_sel, bus_addr, bus_wdata, stallreq_if, stallreq_mem
  );

  modport master (
    output if_req, if_addr, if_flush, mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
           bus_rdata, bus_ack,
    input  if_rdata, if_ready, mem_rdata, mem_ready, bus_err,
           bus_req, bus_we, bus_sel, bus_addr, bus_wdata, stallreq_if, stallreq_mem
  );
endinterface

// File: rtl/bus_arbiter.sv
// Serialises IF fetches and MEM accesses onto one registered request/ack bus.
// MEM has fixed priority; a per-access timeout ends hung accesses with bus_err.
module bus_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic         clk,
  input  logic         rst,
  bus_arbiter_if.slave bif
);
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_BUSY = 2'd1,
    IF_BUSY  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);
  localparam bit               TO_EN  = (TIMEOUT != 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drop_q, drop_d;
  logic             bus_req_q, bus_req_d;
  logic             bus_we_q, bus_we_d;
  logic [3:0]       bus_sel_q, bus_sel_d;
  logic [31:0]      bus_addr_q, bus_addr_d;
  logic [31:0]      bus_wdata_q, bus_wdata_d;
  logic [31:0]      if_rdata_q, if_rdata_d;
  logic             if_ready_q, if_ready_d;
  logic [31:0]      mem_rdata_q, mem_rdata_d;
  logic             mem_ready_q, mem_ready_d;
  logic             bus_err_q, bus_err_d;

  logic mem_elig, if_elig, timed_out, drop_now, done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      drop_q      <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_sel_q   <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      if_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      mem_rdata_q <= '0;
      mem_ready_q <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      drop_q      <= drop_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_sel_q   <= bus_sel_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      if_rdata_q  <= if_rdata_d;
      if_ready_q  <= if_ready_d;
      mem_rdata_q <= mem_rdata_d;
      mem_ready_q <= mem_ready_d;
      bus_err_q   <= bus_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    drop_d      = drop_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_sel_d   = bus_sel_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if_rdata_d  = if_rdata_q;
    if_ready_d  = 1'b0;
    mem_rdata_d = mem_rdata_q;
    mem_ready_d = 1'b0;
    bus_err_d   = 1'b0;

    // A requester whose result is being delivered this cycle must not relaunch.
    mem_elig  = bif.mem_req & ~mem_ready_q;
    if_elig   = bif.if_req & ~if_ready_q;
    timed_out = TO_EN & (cnt_q == TO_CNT);
    drop_now  = drop_q | bif.if_flush;
    done      = bif.bus_ack | timed_out;

    case (state_q)
      IDLE: begin
        bus_req_d = 1'b0;
        drop_d    = 1'b0;
        cnt_d     = '0;
        if (mem_elig) begin
          bus_req_d   = 1'b1;
          bus_we_d    = bif.mem_we;
          bus_sel_d   = bif.mem_sel;
          bus_addr_d  = bif.mem_addr;
          bus_wdata_d = bif.mem_wdata;
          state_d     = MEM_BUSY;
        end else if (if_elig && !bif.if_flush) begin
          bus_req_d  = 1'b1;
          bus_we_d   = 1'b0;
          bus_sel_d  = 4'hF;
          bus_addr_d = bif.if_addr;
          state_d    = IF_BUSY;
        end
      end
      MEM_BUSY: begin
        if (done) begin
          bus_req_d   = 1'b0;
          mem_ready_d = 1'b1;
          bus_err_d   = ~bif.bus_ack;
          mem_rdata_d = (bif.bus_ack && !bus_we_q) ? bif.bus_rdata : '0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      IF_BUSY: begin
        drop_d = drop_now;
        if (done) begin
          bus_req_d = 1'b0;
          drop_d    = 1'b0;
          state_d   = IDLE;
          // A flushed fetch still finishes on the bus but is invisible to the pipeline.
          if (!drop_now) begin
            if_ready_d = 1'b1;
            bus_err_d  = ~bif.bus_ack;
            if_rdata_d = bif.bus_ack ? bif.bus_rdata : '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bif.bus_req      = bus_req_q;
  assign bif.bus_we       = bus_we_q;
  assign bif.bus_sel      = bus_sel_q;
  assign bif.bus_addr     = bus_addr_q;
  assign bif.bus_wdata    = bus_wdata_q;
  assign bif.if_rdata     = if_rdata_q;
  assign bif.if_ready     = if_ready_q;
  assign bif.mem_rdata    = mem_rdata_q;
  assign bif.mem_ready    = mem_ready_q;
  assign bif.bus_err      = bus_err_q;
  assign bif.stallreq_if  = bif.if_req & ~if_ready_q;
  assign bif.stallreq_mem = bif.mem_req & ~mem_ready_q;
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-requester arbiter and sequencer for the core's single external memory bus. It serialises instruction-fetch (IF) and data-memory (MEM) accesses onto one registered request/acknowledge bus, with MEM given fixed priority. It generates the `stallreq_if`/`stallreq_mem` requests consumed by the pipeline stall controller and enforces a bus timeout. It sits between the IF/MEM pipeline stages and the external bus.

## Interface
- `TIMEOUT`, 255: max cycles to wait for `bus_ack` after launch; 0 disables the timeout.
- `CNT_W`, 8: width of the timeout counter; must satisfy TIMEOUT < 2^CNT_W.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `if_req`  in  1  IF stage requests a 32-bit read.
- `if_addr`  in  32  fetch address.
- `if_flush`  in  1  discard the result of the current/pending IF access.
- `if_rdata`  out  32  fetched word; valid while `if_ready`=1.
- `if_ready`  out  1  one-cycle pulse: IF access done.
- `mem_req`  in  1  MEM stage requests an access.
- `mem_we`  in  1  1 = write, 0 = read.
- `mem_sel`  in  4  byte enables.
- `mem_addr`  in  32  data address.
- `mem_wdata`  in  32  write data.
- `mem_rdata`  out  32  read data; valid while `mem_ready`=1.
- `mem_ready`  out  1  one-cycle pulse: MEM access done.
- `bus_err`  out  1  one-cycle pulse, coincident with the ready pulse of a timed-out access.
- `bus_req`, `bus_we`, `bus_sel[3:0]`, `bus_addr[31:0]`, `bus_wdata[31:0]`  out  registered bus request.
- `bus_rdata`  in  32  bus read data, sampled when `bus_ack`=1.
- `bus_ack`  in  1  bus completion, one cycle.
- `stallreq_if`  out  1  `if_req & ~if_ready`, combinational.
- `stallreq_mem`  out  1  `mem_req & ~mem_ready`, combinational.

## Operation
- FSM states: IDLE, MEM_BUSY, IF_BUSY. Reset state is IDLE.
- IDLE: a requester is *eligible* if its req=1 and its ready output is 0 this cycle. This prevents relaunching a request whose result is being delivered.
  - If MEM is eligible: latch its we/sel/addr/wdata onto the bus regs, set `bus_req`, go to MEM_BUSY.
  - Else if IF is eligible and `if_flush`=0: latch `if_addr`, force `bus_we`=0 and `bus_sel`=4'hF, set `bus_req`, go to IF_BUSY.
  - If both are eligible in the same cycle, MEM wins; IF launches on a later IDLE cycle.
- BUSY states: bus outputs are held stable until `bus_ack`.
  - On `bus_ack`: clear `bus_req`, register `bus_rdata` into the owner's rdata, pulse the owner's ready, return to IDLE. For writes, `mem_rdata` = 0.
- Timeout counter: clears on launch and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT (TIMEOUT≠0): clear `bus_req`, pulse the owner's ready with rdata = 0, pulse `bus_err`, go to IDLE.
  - A `bus_ack` in the same cycle as the timeout counts as success.
- Flush: `if_flush` in IF_BUSY sets a drop flag. The bus access still completes, but `if_ready` is suppressed and `if_rdata` is not updated. The flag clears on return to IDLE.
- While idle, all bus outputs other than `bus_req` keep their last values. `bus_req`=0.

## Timing
- Reset (asynchronous): state IDLE, counter 0, drop flag 0. Every registered output = 0: bus_*, if_rdata, mem_rdata, if_ready, mem_ready, bus_err.
  - Reset mid-transaction drops `bus_req` immediately and produces no ready pulse.
- Launch: request eligible at cycle c → `bus_req`=1 from c+1.
- Completion: `bus_ack` sampled at cycle k → ready, rdata and `bus_err` valid in k+1, and `bus_req`=0 in k+1.
  - Minimum latency is req at c, ack at c+1, ready at c+2.
- Ready pulses are exactly one cycle. Stalls deassert in the ready cycle.
- Back-to-back: in cycle k+1 the FSM is IDLE; the other requester can launch, giving `bus_req` again at k+2. Bus utilisation gap = 1 cycle.
- Timeout: launch at c+1, no ack → ready and `bus_err` at c+1+TIMEOUT+1.

## Test plan
- After reset, single IF read at 0x0000_0100, ack 3 cycles after `bus_req` → `if_rdata` = bus data.
  - `if_ready` pulses once.
  - `stallreq_if`=1 from request until the ready cycle.
  - No relaunch in the ready cycle.
- `if_req` and `mem_req` (write, sel=4'b0011, data 0xDEAD_BEEF) both rise in the same cycle → bus carries the MEM write first with `bus_we`=1.
  - `mem_ready` pulses, then IF launches one cycle later.
- `if_flush` asserted mid IF_BUSY, ack returns 0x1234_5678 → no `if_ready` and `if_rdata` unchanged.
  - The next `if_req` launches normally.
- TIMEOUT=4, no `bus_ack` for a MEM read → `mem_ready`=1, `bus_err`=1, `mem_rdata`=0 at launch+5.
  - `bus_req` then drops.
- `rst` pulsed while in MEM_BUSY → all outputs 0 asynchronously.
  - No ready pulse.
  - The first request after reset release launches cleanly.
